// File: rtl/ttt_pkg.sv
// Shared definitions for the tic-tac-toe board serialiser: cell encoding, sizes, tx FSM states.
package ttt_pkg;

    typedef enum logic [1:0] {
        EMPTY   = 2'b00,
        X       = 2'b01,
        O       = 2'b10,
        ILLEGAL = 2'b11
    } cell_e;

    localparam int unsigned NUM_CELLS  = 9;
    localparam int unsigned BOARD_W    = 18;
    localparam int unsigned FRAME_BITS = 21;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_e;

    function automatic logic has_illegal(input logic [BOARD_W-1:0] b);
        logic found;
        found = 1'b0;
        for (int i = 0; i < NUM_CELLS; i++) begin
            if (cell_e'(b[2*i +: 2]) == ILLEGAL) begin
                found = 1'b1;
            end
        end
        return found;
    endfunction

endpackage

// File: rtl/tx_bitcnt.sv
// Modulo-Modulus counter with enable and a one-cycle wrap pulse on the last enabled count.
module tx_bitcnt #(
    parameter int unsigned Modulus = 4,
    parameter int unsigned Width   = (Modulus > 1) ? $clog2(Modulus) : 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    output logic [Width-1:0] count_o,
    output logic             wrap_o
);

    localparam logic [Width-1:0] Last = Width'(Modulus - 1);

    logic [Width-1:0] count_q, count_d;
    logic             last;

    always_comb begin
        last    = (count_q == Last);
        wrap_o  = en_i && last;
        count_d = count_q;
        if (en_i) begin
            count_d = last ? '0 : count_q + Width'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/board_tx.sv
// Serialises a captured 9-cell board as start + 18 data bits (LSB first) + even parity + stop.
module board_tx
    import ttt_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [BOARD_W-1:0] board,
    input  logic               start,
    output logic               txd,
    output logic               busy,
    output logic               done,
    output logic               err
);

    localparam int unsigned PerW = $clog2(CLKS_PER_BIT);
    localparam int unsigned IdxW = $clog2(BOARD_W);

    tx_state_e          state_q, state_d;
    logic [BOARD_W-1:0] shadow_q, shadow_d;
    logic               txd_q, txd_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    logic               per_en, per_wrap;
    logic               idx_en, idx_wrap;
    logic [PerW-1:0]    per_cnt;
    logic [IdxW-1:0]    idx_cnt, idx_nxt;
    logic               illegal, accept;

    tx_bitcnt #(
        .Modulus (CLKS_PER_BIT),
        .Width   (PerW)
    ) u_per_cnt (
        .clk_i   (clk),
        .rst_i   (reset),
        .en_i    (per_en),
        .count_o (per_cnt),
        .wrap_o  (per_wrap)
    );

    tx_bitcnt #(
        .Modulus (BOARD_W),
        .Width   (IdxW)
    ) u_idx_cnt (
        .clk_i   (clk),
        .rst_i   (reset),
        .en_i    (idx_en),
        .count_o (idx_cnt),
        .wrap_o  (idx_wrap)
    );

    always_comb begin
        illegal = has_illegal(board);
        accept  = (state_q == IDLE) && start && !illegal;
        per_en  = (state_q != IDLE);
        idx_en  = (state_q == DATA) && per_wrap;

        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept)   state_d = START;
            START:   if (per_wrap) state_d = DATA;
            DATA:    if (idx_wrap) state_d = PARITY;
            PARITY:  if (per_wrap) state_d = STOP;
            STOP:    if (per_wrap) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Index the bit that will be on the line next cycle so txd can stay a flop.
        idx_nxt = idx_cnt;
        if (idx_wrap) begin
            idx_nxt = '0;
        end else if (idx_en) begin
            idx_nxt = idx_cnt + IdxW'(1);
        end

        shadow_d = accept ? board : shadow_q;

        txd_d = 1'b1;
        unique case (state_d)
            IDLE:    txd_d = 1'b1;
            START:   txd_d = 1'b0;
            DATA:    txd_d = shadow_q[idx_nxt];
            PARITY:  txd_d = ^shadow_q;
            STOP:    txd_d = 1'b1;
            default: txd_d = 1'b1;
        endcase

        busy_d = (state_d != IDLE);
        done_d = (state_q == STOP) && per_wrap;
        err_d  = (state_q == IDLE) && start && illegal;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            shadow_q <= '0;
            txd_q    <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            txd_q    <= txd_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign txd  = txd_q;
    assign busy = busy_q;
    assign done = done_q;
    assign err  = err_q;

    per_cnt_in_range: assert property (@(posedge clk) disable iff (reset)
        32'(per_cnt) < CLKS_PER_BIT);

endmodule

// File: tb/tb_board_tx.sv
// Directed self-checking bench for board_tx with CLKS_PER_BIT = 4.
module tb_board_tx;

    localparam int unsigned CPB    = 4;
    localparam int          FRAMEC = 21 * CPB;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [17:0] board;
    logic        txd, busy, done, err;

    int total = 0;
    int bad   = 0;

    board_tx #(
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .board (board),
        .start (start),
        .txd   (txd),
        .busy  (busy),
        .done  (done),
        .err   (err)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Line level k cycles after the accepting edge: start, 18 data bits, parity, stop.
    function automatic logic exp_bit(input logic [17:0] b, input logic par, input int k);
        int slot;
        slot = k / CPB;
        if (slot == 0) return 1'b0;
        if (slot <= 18) return b[slot-1];
        if (slot == 19) return par;
        return 1'b1;
    endfunction

    task automatic run_frame(input logic [17:0] b, input logic par, input logic disturb,
                             input string name);
        board = b;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < FRAMEC; k++) begin
            total++;
            if (txd !== exp_bit(b, par, k) || busy !== 1'b1 || done !== 1'b0 || err !== 1'b0)
            begin
                bad++;
                $display("FAIL %s cycle %0d: txd=%b busy=%b done=%b err=%b want txd=%b busy=1 done=0 err=0",
                         name, k, txd, busy, done, err, exp_bit(b, par, k));
            end
            if (disturb && k == 30) begin
                board = 18'h15555;
                start = 1'b1;
            end
            if (disturb && k == 31) start = 1'b0;
            tick();
        end
        total++;
        if (done !== 1'b1 || busy !== 1'b0 || txd !== 1'b1) begin
            bad++;
            $display("FAIL %s end: done=%b busy=%b txd=%b want done=1 busy=0 txd=1",
                     name, done, busy, txd);
        end
    endtask

    task automatic check_idle(input string name);
        total++;
        if (done !== 1'b0 || busy !== 1'b0 || txd !== 1'b1 || err !== 1'b0) begin
            bad++;
            $display("FAIL %s: done=%b busy=%b txd=%b err=%b want 0 0 1 0",
                     name, done, busy, txd, err);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        start = 1'b0;
        board = '0;
        tick();
        tick();
        total++;
        if (txd !== 1'b1) begin bad++; $display("FAIL reset_txd: got %b want 1", txd); end
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++;
        if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
        total++;
        if (err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", err); end
        reset = 1'b0;
        tick();
        check_idle("after_reset_release");
    endtask

    task automatic test_frames;
        run_frame(18'h00000, 1'b0, 1'b0, "frame_zero");
        tick();
        check_idle("frame_zero_done_one_cycle");
        run_frame(18'h00001, 1'b1, 1'b0, "frame_one");
        tick();
        run_frame(18'h2AAAA, 1'b1, 1'b0, "frame_alt");
        tick();
        run_frame(18'h00006, 1'b0, 1'b0, "frame_mixed");
        tick();
    endtask

    task automatic test_illegal(input logic [17:0] b, input string name);
        board = b;
        start = 1'b1;
        tick();
        start = 1'b0;
        total++;
        if (err !== 1'b1 || busy !== 1'b0 || txd !== 1'b1) begin
            bad++;
            $display("FAIL %s pulse: err=%b busy=%b txd=%b want err=1 busy=0 txd=1",
                     name, err, busy, txd);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            check_idle(name);
        end
    endtask

    task automatic test_ignore_midframe;
        run_frame(18'h2AAAA, 1'b1, 1'b1, "frame_disturbed");
        for (int i = 0; i < 6; i++) begin
            tick();
            check_idle("no_queued_frame");
        end
    endtask

    task automatic test_back_to_back;
        run_frame(18'h00001, 1'b1, 1'b0, "b2b_first");
        run_frame(18'h2AAAA, 1'b1, 1'b0, "b2b_second");
        tick();
        check_idle("b2b_tail");
    endtask

    task automatic test_reset_midframe;
        int stray;
        board = 18'h00000;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 33; k++) tick();
        total++;
        if (txd !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL abort_pre: txd=%b busy=%b want txd=0 busy=1", txd, busy);
        end
        #1 reset = 1'b1;
        #1;
        total++;
        if (txd !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL abort_now: txd=%b busy=%b done=%b want 1 0 0", txd, busy, done);
        end
        tick();
        reset = 1'b0;
        stray = 0;
        for (int i = 0; i < 90; i++) begin
            tick();
            if (done !== 1'b0 || busy !== 1'b0) stray++;
        end
        total++;
        if (stray != 0) begin
            bad++;
            $display("FAIL abort_quiet: %0d cycles with done/busy set, want 0", stray);
        end
        run_frame(18'h00001, 1'b1, 1'b0, "after_abort");
        tick();
    endtask

    initial begin
        test_reset();
        test_frames();
        test_illegal(18'h00003, "illegal_cell0");
        test_illegal(18'h30000, "illegal_cell8");
        test_ignore_midframe();
        test_back_to_back();
        test_reset_midframe();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/board_tx.md
BOARD_TX -- requirements
Module: board_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 4, clock cycles per serial bit (legal range 2..255).
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 board  input  18  board snapshot source; cell i = board[2i+1:2i]; 00 empty, 01 X, 10 O, 11 illegal.
REQ-005 start  input  1  request to transmit current board; sampled only in IDLE.
REQ-006 txd  output  1  serial line; idle level 1.
REQ-007 busy  output  1  high while a frame is in progress.
REQ-008 done  output  1  one-cycle pulse at frame completion.
REQ-009 err  output  1  one-cycle pulse when a start is rejected for an illegal cell.

Function
REQ-010 States SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-011 Frame SHALL be: start bit 0, 18 data bits board[0] first to board[17] last, even-parity bit, stop bit 1; 21 bits total.
REQ-012 Each bit SHALL be held on txd for exactly CLKS_PER_BIT cycles; frame length 21*CLKS_PER_BIT cycles.
REQ-013 In IDLE, start=1 with no cell equal to 11 SHALL capture board into a shadow register and enter START; txd=0 and busy=1 from the following cycle.
REQ-014 In IDLE, start=1 with any cell equal to 11 SHALL stay in IDLE, txd stays 1, err=1 for the following cycle only.
REQ-015 Transmitted data and parity SHALL come from the shadow copy; board changes during a frame SHALL have no effect.
REQ-016 Parity bit SHALL equal XOR of the 18 captured bits (total ones incl. parity even).
REQ-017 start while busy=1 SHALL be ignored, not queued.
REQ-018 After the last STOP cycle the FSM SHALL return to IDLE with busy=0 and done=1 for that one cycle.
REQ-019 start=1 in the cycle done=1 SHALL be accepted (back-to-back frames, zero idle gap beyond that cycle).
REQ-020 Bit-period counter and bit-index counter SHALL wrap to 0 at CLKS_PER_BIT-1 and 17 respectively; no other wrap.
REQ-021 txd, busy, done, err SHALL be registered outputs (no combinational path from inputs).

Reset
REQ-022 reset=1 SHALL immediately force state IDLE, txd=1, busy=0, done=0, err=0, counters and shadow register 0.
REQ-023 reset mid-frame SHALL abort the frame without done; first start after deassertion SHALL begin a fresh frame.

Structure
REQ-024 Shared package ttt_pkg SHALL hold cell encoding enum (EMPTY, X, O, ILLEGAL), NUM_CELLS=9, BOARD_W=18, FRAME_BITS=21, and the tx state enum.
REQ-025 One sub-module tx_bitcnt (parameterised modulo counter with enable, async reset, wrap pulse) SHALL implement both counters.

Verification
REQ-026 CLKS_PER_BIT=4, board=18'h00000, start pulse -> txd: 4x0, 72x0, 4x0 parity, 4x1; done one cycle at cycle 84 after accept.
REQ-027 board=18'h00001 -> first data bit 1, rest 0, parity 1; board=18'h2AAAA -> data alternates 0,1 starting 0, parity 1.
REQ-028 board=18'h00003 (cell0=11), start -> no frame, txd stays 1, err=1 one cycle, busy stays 0.
REQ-029 Change board and pulse start mid-frame -> frame bits unchanged, no second frame; start held during done cycle -> second frame begins next cycle.
REQ-030 Assert reset at data bit 7 -> txd=1, busy=0 same cycle, no done; subsequent start yields a complete correct frame.
